// File: rtl/dac_output_stream.sv
// dac_output_stream: plays a 16-bit AXI-Stream sample burst out to a parallel DAC.
// Ports: ACLK/ARESETN clock and async active-low reset; s_axis_* slave stream (tkeep is
//   ignored, tlast is used only by the optional checker); start/test/dsize are control
//   bits from the register bank; dac_data/dac_valid drive the DAC; busy/sr_pc/underrun/
//   tlast_err are status bits.
// Optional feature: define DAC_OUTPUT_TLAST_CHECK_EN to build the tlast-vs-dsize checker.

// Generic single-clock sample FIFO, power-of-2 depth, pointers wrap naturally.
// Latency: head_dat shows the oldest entry combinationally; a push is visible next cycle.
// Backpressure: full/empty flags only; the owner never pushes when full or pops when empty.
module dac_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_rdy})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// Burst player: launch on start rising edge, preload FIFO, then one sample per clock.
// Latency: dac_data/dac_valid are registered, one cycle after the FIFO pop.
// Backpressure: s_axis_tready drops when FIFO full, in test mode, or once dsize beats taken.
module dac_output_stream #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int PRELOAD    = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [1:0]        s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              start,
  input  logic              test,
  input  logic [31:0]       dsize,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              sr_pc,
  output logic              underrun,
  output logic              tlast_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PRELOAD_CNT = CW'(PRELOAD);

  typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

  state_t             state;
  logic               start_q;
  logic               test_q;
  logic [31:0]        dsize_q;
  logic [31:0]        rx_cnt;
  logic [31:0]        tx_cnt;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_head;
  logic               launch;
  logic               push;
  logic               pop;
  logic               rx_open;
  logic               tx_open;

  // Counters never exceed dsize_q, so these compares cannot overflow even at 2^32-1.
  assign rx_open = (rx_cnt < dsize_q);
  assign tx_open = (tx_cnt < dsize_q);
  assign launch  = start & ~start_q & (state == IDLE);

  assign s_axis_tready = ((state == FILL) || (state == PLAY)) & ~test_q & ~fifo_full & rx_open;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = (state == PLAY) & ~test_q & ~fifo_empty & tx_open;
  assign busy          = (state != IDLE);

  dac_sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .push_vld (push),
    .push_dat (s_axis_tdata),
    .pop_rdy  (pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) start_q <= 1'b0;
    else          start_q <= start;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      test_q    <= 1'b0;
      dsize_q   <= '0;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      sr_pc     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (push) rx_cnt <= rx_cnt + 32'd1;
      case (state)
        IDLE: begin
          dac_valid <= 1'b0;
          if (launch) begin
            dsize_q  <= dsize;
            test_q   <= test;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            underrun <= 1'b0;
            // A zero-length burst completes immediately without leaving IDLE.
            sr_pc    <= (dsize == '0);
            if (dsize != '0) state <= test ? PLAY : FILL;
          end
        end
        FILL: begin
          dac_valid <= 1'b0;
          // Short bursts may never reach the preload level; start once all beats are in.
          if (fifo_count >= PRELOAD_CNT || !rx_open) state <= PLAY;
        end
        PLAY: begin
          if (!tx_open) begin
            // Last sample was shown in the previous cycle; finish here.
            state     <= IDLE;
            sr_pc     <= 1'b1;
            dac_valid <= 1'b0;
          end else if (test_q) begin
            dac_data  <= DATA_W'(tx_cnt);
            dac_valid <= 1'b1;
            tx_cnt    <= tx_cnt + 32'd1;
          end else if (pop) begin
            dac_data  <= fifo_head;
            dac_valid <= 1'b1;
            tx_cnt    <= tx_cnt + 32'd1;
          end else begin
            // Starved: hold the last sample on the DAC and flag it.
            dac_valid <= 1'b0;
            underrun  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          dac_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAC_OUTPUT_TLAST_CHECK_EN
  logic last_beat;
  // Only evaluated on accepted beats, where dsize_q >= 1, so no underflow.
  assign last_beat = (rx_cnt == (dsize_q - 32'd1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                               tlast_err <= 1'b0;
    else if (launch)                            tlast_err <= 1'b0;
    else if (push && (s_axis_tlast != last_beat)) tlast_err <= 1'b1;
  end

  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;
`else
  assign tlast_err = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast};
`endif

endmodule

// File: tb/tb_dac_output_stream.sv
`timescale 1ns/1ps
module tb_dac_output_stream;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int PRELOAD    = 8;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [1:0]        s_axis_tkeep = 2'b11;
  logic              s_axis_tlast = 1'b0;
  logic              start = 1'b0;
  logic              test = 1'b0;
  logic [31:0]       dsize = '0;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              busy;
  logic              sr_pc;
  logic              underrun;
  logic              tlast_err;

  always #5 ACLK = ~ACLK;

  dac_output_stream #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PRELOAD    (PRELOAD)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .start         (start),
    .test          (test),
    .dsize         (dsize),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid),
    .busy          (busy),
    .sr_pc         (sr_pc),
    .underrun      (underrun),
    .tlast_err     (tlast_err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected DAC samples in playout order.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_dat = '0;
  bit cur_test   = 1'b0;
  bit contig     = 1'b0;
  bit seen_first = 1'b0;
  int cur_n      = 0;
  int acc_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples DAC side on the falling edge, independent of the stimulus.
  initial begin
    logic [DATA_W-1:0] e;
    int thr;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        last_dat = '0;
      end else begin
        if (cur_test) check("tready_in_test", 64'(s_axis_tready), 64'd0);
        if (dac_valid) begin
          if (!seen_first && !cur_test) begin
            thr = (cur_n < PRELOAD) ? cur_n : PRELOAD;
            check("preload_before_play", 64'(acc_cnt >= thr), 64'd1);
          end
          seen_first = 1'b1;
          check("sample_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dac_data", 64'(dac_data), 64'(e));
          end
          last_dat = dac_data;
        end else begin
          check("dac_data_hold", 64'(dac_data), 64'(last_dat));
          if (contig && seen_first && exp_q.size() != 0)
            check("contiguous_valid", 64'(dac_valid), 64'd1);
        end
      end
    end
  end

  task automatic launch(input int n, input bit tst, input bit hold);
    @(posedge ACLK); #1;
    exp_q.delete();
    seen_first = 1'b0;
    acc_cnt    = 0;
    cur_n      = n;
    cur_test   = tst;
    if (tst) for (int i = 0; i < n; i++) exp_q.push_back(DATA_W'(i));
    dsize = 32'(n);
    test  = tst;
    start = 1'b1;
    @(posedge ACLK); #1;
    if (!hold) start = 1'b0;
    @(negedge ACLK);
    check("busy_after_launch", 64'(busy), 64'(n != 0));
    check("sr_pc_after_launch", 64'(sr_pc), 64'(n == 0));
    check("underrun_cleared", 64'(underrun), 64'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic finish_burst(input int exp_underrun, input bit exp_tlast);
    int w = 0;
    @(negedge ACLK);
    while (busy && w < 500) begin
      @(negedge ACLK);
      w++;
    end
    check("burst_completes", 64'(busy), 64'd0);
    check("sr_pc_set", 64'(sr_pc), 64'd1);
    check("all_samples_out", 64'(exp_q.size()), 64'd0);
    if (exp_underrun >= 0) check("underrun", 64'(underrun), 64'(exp_underrun[0]));
`ifdef DAC_OUTPUT_TLAST_CHECK_EN
    check("tlast_err", 64'(tlast_err), 64'(exp_tlast));
`else
    check("tlast_err", 64'(tlast_err), 64'(exp_tlast & 1'b0));
`endif
    contig = 1'b0;
    @(posedge ACLK); #1;
  endtask

  // Drives one burst. pct = tvalid probability, stall_len idle cycles once stall_after
  // beats have gone, tlast_pos = beat carrying tlast, abort_cyc >= 0 leaves mid-burst.
  task automatic run_burst(input int n, input bit tst, input logic [DATA_W-1:0] base,
                           input int pct, input int stall_after, input int stall_len,
                           input int tlast_pos, input int exp_underrun, input bit cont,
                           input int abort_cyc);
    int sent = 0;
    int stalled = 0;
    int cyc = 0;
    bit v;
    contig = cont;
    launch(n, tst, 1'b0);
    if (tst) begin
      for (int i = 0; i < n + 2; i++) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = base;
        @(posedge ACLK); #1;
      end
    end else begin
      while (sent < n && cyc < 4000) begin
        if (cyc == abort_cyc) return;
        if (sent == stall_after && stalled < stall_len) begin
          v = 1'b0;
          stalled++;
        end else begin
          v = ($urandom_range(99) < pct);
        end
        s_axis_tvalid = v;
        s_axis_tdata  = base + DATA_W'(sent);
        s_axis_tlast  = (sent + 1 == tlast_pos);
        @(negedge ACLK);
        if (v && s_axis_tready) begin
          exp_q.push_back(s_axis_tdata);
          sent++;
          acc_cnt = sent;
        end
        @(posedge ACLK); #1;
        cyc++;
      end
      check("all_beats_accepted", 64'(sent), 64'(n));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + DATA_W'(n);
      s_axis_tlast  = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge ACLK);
        check("tready_after_dsize", 64'(s_axis_tready), 64'd0);
        @(posedge ACLK); #1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    finish_burst(exp_underrun, !tst && (n > 0) && (tlast_pos != n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dac_data"},  64'(dac_data),      64'd0);
    check({tag, "_dac_valid"}, 64'(dac_valid),     64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_sr_pc"},     64'(sr_pc),         64'd0);
    check({tag, "_underrun"},  64'(underrun),      64'd0);
    check({tag, "_tlast_err"}, 64'(tlast_err),     64'd0);
    check({tag, "_tready"},    64'(s_axis_tready), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks, expected finish", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;

    // Full-rate source, 32 beats: contiguous playout, no underrun.
    run_burst(32, 1'b0, 16'h1000, 100, -1, 0, 32, 0, 1'b1, -1);
    // Source stalls 10 cycles after beat 12: gaps with held data and underrun.
    run_burst(20, 1'b0, 16'h2000, 100, 12, 10, 20, 1, 1'b0, -1);
    // Burst shorter than the preload level.
    run_burst(4, 1'b0, 16'h3000, 100, -1, 0, 4, 0, 1'b1, -1);
    // Test ramp.
    run_burst(5, 1'b1, 16'hbeef, 100, -1, 0, 0, 0, 1'b1, -1);

    // start held high with a re-pulse mid-burst: exactly one burst, no relaunch.
    contig = 1'b1;
    launch(12, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) start = 1'b0;
      if (i == 4) start = 1'b1;
      @(posedge ACLK); #1;
    end
    finish_burst(0, 1'b0);
    repeat (5) @(posedge ACLK);
    #1;
    check("no_relaunch_busy", 64'(busy), 64'd0);
    start = 1'b0;

    // Zero-length burst.
    launch(0, 1'b0, 1'b0);
    repeat (4) @(posedge ACLK);
    #1;
    finish_burst(0, 1'b0);

    // Reset in the middle of PLAY, then a clean burst proves the FIFO was flushed.
    run_burst(30, 1'b0, 16'h4000, 100, -1, 0, 30, -1, 1'b0, 14);
    ARESETN = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    contig = 1'b0;
    @(negedge ACLK);
    check_all_zero("midreset");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    run_burst(10, 1'b0, 16'h5000, 100, -1, 0, 10, 0, 1'b1, -1);

    // tlast placement.
    run_burst(8, 1'b0, 16'h6000, 100, -1, 0, 6, 0, 1'b1, -1);
    run_burst(8, 1'b0, 16'h7000, 100, -1, 0, 8, 0, 1'b1, -1);

    // Randomized bursts.
    for (int k = 0; k < 10; k++) begin
      int n;
      bit tst;
      n   = $urandom_range(40, 1);
      tst = ($urandom_range(3) == 0);
      run_burst(n, tst, DATA_W'($urandom), $urandom_range(100, 25), -1, 0, n,
                tst ? 0 : -1, tst, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
